ysyx_23060187_multicycle_ctrl: RTL and testbench

//  Multi-cycle NPC control unit: full RV32I/RV64I decode plus FETCH->DECODE->EXEC->MEM->WB sequencer.

---
 rtl/ysyx_23060187_multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_23060187_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060187_multicycle_ctrl.sv
// ysyx_23060187_multicycle_ctrl: RV32I/RV64I decode plus FETCH->DECODE->EXEC->MEM->WB sequencer
// with LSU handshake, optional LSU timeout and sticky halt/illegal flags.
module ysyx_23060187_multicycle_ctrl #(
    parameter int XLEN    = 32,
    parameter int ALU_W   = 4,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [31:0]      inst,
    input  logic             cmp_true,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    output logic             lsu_we,
    input  logic             lsu_rvalid,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [2:0]       imm_sel,
    output logic             word_op,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             halt,
    output logic             illegal,
    output logic [2:0]       state_o
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE, EXEC, MEM, WB, HALT} state_t;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [ALU_W-1:0] ADD = ALU_W'(0), SUB = ALU_W'(1), SLL = ALU_W'(2), SLT = ALU_W'(3),
        SLTU = ALU_W'(4), XOR = ALU_W'(5), SRL = ALU_W'(6), SRA = ALU_W'(7), OR = ALU_W'(8),
        AND = ALU_W'(9), PASSB = ALU_W'(10);
    localparam bit RV64 = XLEN == 64;
    state_t state, state_nx;
    logic [31:0] ir;
    logic [CW-1:0] cnt;
    logic is_ld, is_st, is_jmp, is_br, wr_rd, taken, acc, set_ill, mem_done;
    logic [1:0] wb_r;
    logic d_ill, d_a, d_b, d_word, d_wr, d_ld, d_st, d_jmp, d_br;
    logic [ALU_W-1:0] d_alu;
    logic [2:0] d_imm;
    logic [1:0] d_wb;
    logic [6:0] op, f7;
    logic [2:0] f3;
    assign op = ir[6:0];
    assign f3 = ir[14:12];
    assign f7 = ir[31:25];

    function automatic logic [ALU_W-1:0] alu_of(input logic [2:0] f, input logic alt);
        case (f)
            3'd0: alu_of = alt ? SUB : ADD;
            3'd1: alu_of = SLL;
            3'd2: alu_of = SLT;
            3'd3: alu_of = SLTU;
            3'd4: alu_of = XOR;
            3'd5: alu_of = alt ? SRA : SRL;
            3'd6: alu_of = OR;
            default: alu_of = AND;
        endcase
    endfunction

    always_comb begin
        d_ill = 1'b0; d_alu = ADD; d_a = 1'b0; d_b = 1'b1; d_imm = 3'd0; d_word = 1'b0;
        d_wr = 1'b0; d_wb = 2'd0; d_ld = 1'b0; d_st = 1'b0; d_jmp = 1'b0; d_br = 1'b0;
        case (op)
            7'h37: begin d_alu = PASSB; d_imm = 3'd3; d_wr = 1'b1; end
            7'h17: begin d_a = 1'b1; d_imm = 3'd3; d_wr = 1'b1; end
            7'h6f: begin d_a = 1'b1; d_imm = 3'd4; d_wr = 1'b1; d_wb = 2'd2; d_jmp = 1'b1; end
            7'h67: begin d_ill = f3 != 3'd0; d_wr = 1'b1; d_wb = 2'd2; d_jmp = 1'b1; end
            7'h63: begin
                d_ill = f3[2:1] == 2'b01; d_b = 1'b0; d_imm = 3'd2; d_br = 1'b1;
                d_alu = !f3[2] ? SUB : f3[1] ? SLTU : SLT;
            end
            7'h03: begin
                d_ill = f3 == 3'd7 || (!RV64 && (f3 == 3'd3 || f3 == 3'd6));
                d_ld = 1'b1; d_wr = 1'b1; d_wb = 2'd1;
            end
            7'h23: begin d_ill = f3[2] || (!RV64 && f3 == 3'd3); d_st = 1'b1; d_imm = 3'd1; end
            7'h13: begin
                d_wr = 1'b1; d_alu = alu_of(f3, f3 == 3'd5 && ir[30]);
                d_ill = f3 == 3'd1 ? (RV64 ? ir[31:26] != 6'd0 : f7 != 7'd0) :
                        f3 == 3'd5 ? (RV64 ? {ir[31], ir[29:26]} != 5'd0 : {f7[6], f7[4:0]} != 6'd0) : 1'b0;
            end
            7'h33: begin
                d_b = 1'b0; d_wr = 1'b1; d_alu = alu_of(f3, ir[30]);
                d_ill = {f7[6], f7[4:0]} != 6'd0 || (ir[30] && f3 != 3'd0 && f3 != 3'd5);
            end
            7'h1b: begin
                d_word = 1'b1; d_wr = 1'b1; d_alu = alu_of(f3, f3 == 3'd5 && ir[30]);
                d_ill = !RV64 || !(f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'd0) ||
                        (f3 == 3'd5 && {f7[6], f7[4:0]} == 6'd0));
            end
            7'h3b: begin
                d_b = 1'b0; d_word = 1'b1; d_wr = 1'b1; d_alu = alu_of(f3, ir[30]);
                d_ill = !RV64 || {f7[6], f7[4:0]} != 6'd0 ||
                        !(f3 == 3'd0 || f3 == 3'd5 || (f3 == 3'd1 && !ir[30]));
            end
            7'h73: d_ill = ir != 32'h0000_0073;
            7'h0f: d_ill = f3 != 3'd0;
            default: d_ill = 1'b1;
        endcase
    end

    // A load may see rvalid in the same cycle the request is accepted
    assign mem_done = is_st ? lsu_req_ready : lsu_rvalid && (acc || lsu_req_ready);

    always_comb begin
        state_nx = state;
        set_ill = 1'b0;
        case (state)
            FETCH: state_nx = inst_valid ? DECODE : FETCH;
            DECODE: begin
                state_nx = (ir == EBREAK || d_ill) ? HALT : EXEC;
                set_ill = ir != EBREAK && d_ill;
            end
            EXEC: state_nx = (is_ld || is_st) ? MEM : WB;
            MEM: begin
                set_ill = !mem_done && TIMEOUT > 0 && cnt == TMAX;
                state_nx = mem_done ? WB : set_ill ? HALT : MEM;
            end
            WB: state_nx = FETCH;
            HALT: state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ir <= '0;
            cnt <= '0;
            acc <= 1'b0;
            taken <= 1'b0;
            illegal <= 1'b0;
            alu_ctrl <= '0;
            alu_src_a <= 1'b0;
            alu_src_b <= 1'b0;
            imm_sel <= '0;
            word_op <= 1'b0;
            wr_rd <= 1'b0;
            wb_r <= '0;
            is_ld <= 1'b0;
            is_st <= 1'b0;
            is_jmp <= 1'b0;
            is_br <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FETCH && inst_valid) ir <= inst;
            if (state == DECODE) begin
                alu_ctrl <= d_alu;
                alu_src_a <= d_a;
                alu_src_b <= d_b;
                imm_sel <= d_imm;
                word_op <= d_word;
                wr_rd <= d_wr && ir[11:7] != 5'd0;
                wb_r <= d_wb;
                is_ld <= d_ld;
                is_st <= d_st;
                is_jmp <= d_jmp;
                is_br <= d_br;
            end
            if (state == EXEC) begin
                taken <= cmp_true ^ f3[0];
                cnt <= '0;
                acc <= 1'b0;
            end else if (state == MEM) begin
                cnt <= cnt + 1'b1;
                if (lsu_req_valid && lsu_req_ready) acc <= 1'b1;
            end
            if (set_ill) illegal <= 1'b1;
        end
    end

    assign inst_ready = state == FETCH;
    assign lsu_req_valid = state == MEM && !acc;
    assign lsu_we = lsu_req_valid && is_st;
    assign pc_we = state == WB;
    assign pc_sel = state == WB && (is_jmp || (is_br && taken));
    assign rf_we = state == WB && wr_rd;
    assign wb_sel = state == WB ? wb_r : 2'd0;
    assign halt = state == HALT;
    assign state_o = state;
endmodule

// File: tb/tb_ysyx_23060187_multicycle_ctrl.sv
// tb_ysyx_23060187_multicycle_ctrl: randomized instruction stream checked against a table of
// instruction classes and their expected control fields, plus directed timeout/reset cases.
module tb_ysyx_23060187_multicycle_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0, cmp_true = 1'b0;
    logic lsu_req_ready = 1'b0, lsu_rvalid = 1'b0;
    logic [31:0] inst = '0;
    logic inst_ready, lsu_req_valid, lsu_we, alu_src_a, alu_src_b, word_op, rf_we, pc_we, pc_sel;
    logic halt, illegal;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_sel, state_o;
    logic [1:0] wb_sel;
    int n_cmp = 0, n_err = 0;

    ysyx_23060187_multicycle_ctrl #(.XLEN(32), .ALU_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .cmp_true(cmp_true), .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_we(lsu_we), .lsu_rvalid(lsu_rvalid), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_sel(imm_sel), .word_op(word_op), .rf_we(rf_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .halt(halt), .illegal(illegal),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit exact; logic [31:0] word; int op, f3, f7;
        bit ill, ebk, nop; int alu, a, b, imm, wr, wb, mem, jmp, br, inv;
    } tmpl_t;
    tmpl_t tq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void add(bit exact, logic [31:0] word, int op, int f3, int f7, bit ill, bit ebk,
                                bit nop, int alu, int a, int b, int imm, int wr, int wb, int mem,
                                int jmp, int br, int inv);
        tmpl_t t;
        t.exact = exact; t.word = word; t.op = op; t.f3 = f3; t.f7 = f7;
        t.ill = ill; t.ebk = ebk; t.nop = nop; t.alu = alu; t.a = a; t.b = b; t.imm = imm;
        t.wr = wr; t.wb = wb; t.mem = mem; t.jmp = jmp; t.br = br; t.inv = inv;
        tq.push_back(t);
    endfunction

    function automatic void ok(int op, int f3, int f7, int alu, int a, int b, int imm, int wr,
                               int wb, int mem, int jmp, int br, int inv);
        add(0, 0, op, f3, f7, 0, 0, 0, alu, a, b, imm, wr, wb, mem, jmp, br, inv);
    endfunction

    function automatic void bad(int op, int f3, int f7);
        add(0, 0, op, f3, f7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [31:0] gen(tmpl_t t);
        logic [31:0] w = $urandom;
        if (t.exact) return t.word;
        w[6:0] = t.op[6:0];
        if (t.f3 >= 0) w[14:12] = t.f3[2:0];
        if (t.f7 >= 0) w[31:25] = t.f7[6:0];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_state", state_o, 0);
        chk("rst_halt", halt, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_strobes", {pc_we, rf_we, lsu_req_valid}, 0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic fetch(input logic [31:0] w);
        chk("fetch_state", state_o, 0);
        chk("fetch_ready", inst_ready, 1);
        inst_valid = 1'b1;
        inst = w;
        step();
        inst_valid = 1'b0;
        inst = $urandom;
        chk("decode_state", state_o, 1);
        chk("decode_ready", inst_ready, 0);
        step();
    endtask

    task automatic run(input tmpl_t t, input int rd_d, input int rv_d, input bit cmp);
        logic [31:0] w = gen(t);
        int last;
        fetch(w);
        if (t.ill || t.ebk) begin
            chk("halt_state", state_o, 5);
            chk("halt", halt, 1);
            chk("halt_illegal", illegal, t.ill);
            inst_valid = 1'b1;
            step();
            inst_valid = 1'b0;
            chk("halt_sticky", {halt, state_o}, {1'b1, 3'd5});
            chk("halt_strobes", {inst_ready, pc_we, rf_we, pc_sel, lsu_req_valid, wb_sel}, 0);
            do_reset();
            return;
        end
        chk("exec_state", state_o, 2);
        if (!t.nop) begin
            chk("alu_ctrl", alu_ctrl, t.alu);
            chk("src_ab", {alu_src_a, alu_src_b}, {t.a[0], t.b[0]});
            chk("imm_sel", imm_sel, t.imm);
            chk("word_op", word_op, 0);
        end
        cmp_true = cmp;
        step();
        cmp_true = 1'b0;
        if (t.mem != 0) begin
            last = t.mem == 2 ? rd_d : rd_d + rv_d;
            for (int k = 0; k <= last; k++) begin
                lsu_req_ready = k == rd_d;
                lsu_rvalid = t.mem == 1 && k == rd_d + rv_d;
                chk("mem_state", state_o, 3);
                chk("req_valid", lsu_req_valid, k <= rd_d);
                if (k <= rd_d) chk("lsu_we", lsu_we, t.mem == 2);
                step();
                lsu_req_ready = 1'b0;
                lsu_rvalid = 1'b0;
            end
        end
        chk("wb_state", state_o, 4);
        chk("pc_we", pc_we, 1);
        chk("pc_sel", pc_sel, t.jmp != 0 || (t.br != 0 && (cmp ^ t.inv[0])));
        chk("rf_we", rf_we, t.wr != 0 && w[11:7] != 0);
        chk("wb_sel", wb_sel, t.wb);
        step();
        chk("next_fetch", {state_o, pc_we, rf_we}, 0);
    endtask

    initial begin
        add(1, 32'h0050_0093, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 32'h0080_00ef, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 1, 2, 0, 1, 0, 0);
        add(1, 32'h0000_0463, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        add(1, 32'h0000_1463, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1);
        add(1, 32'h0000_a103, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        add(1, 32'h0010_0073, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 32'hffff_ffff, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 32'h0000_0073, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ok('h37, -1, -1, 10, 0, 1, 3, 1, 0, 0, 0, 0, 0);
        ok('h17, -1, -1, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0);
        ok('h6f, -1, -1, 0, 1, 1, 4, 1, 2, 0, 1, 0, 0);
        ok('h67, 0, -1, 0, 0, 1, 0, 1, 2, 0, 1, 0, 0);
        ok('h63, 0, -1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        ok('h63, 1, -1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1);
        ok('h63, 4, -1, 3, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        ok('h63, 5, -1, 3, 0, 0, 2, 0, 0, 0, 0, 1, 1);
        ok('h63, 6, -1, 4, 0, 0, 2, 0, 0, 0, 0, 1, 0);
        ok('h63, 7, -1, 4, 0, 0, 2, 0, 0, 0, 0, 1, 1);
        for (int f = 0; f < 6; f++) if (f != 3) ok('h03, f, -1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
        for (int f = 0; f < 3; f++) ok('h23, f, -1, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0);
        ok('h13, 0, -1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h13, 2, -1, 3, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h13, 3, -1, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h13, 4, -1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h13, 6, -1, 8, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h13, 7, -1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h13, 1, 0, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h13, 5, 0, 6, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h13, 5, 'h20, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 0, 'h20, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 2, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 3, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 4, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 5, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 5, 'h20, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 6, 0, 8, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        ok('h33, 7, 0, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 'h0f, 0, -1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bad('h1b, -1, -1); bad('h3b, -1, -1); bad('h67, 1, -1); bad('h03, 3, -1);
        bad('h03, 7, -1); bad('h23, 4, -1); bad('h23, 3, -1); bad('h63, 2, -1);
        bad('h33, 0, 1); bad('h13, 1, 'h20); bad('h73, 1, -1); bad('h00, -1, -1);

        #12;
        chk("init_state", state_o, 0);
        chk("init_flags", {halt, illegal}, 0);
        chk("init_strobes", {pc_we, rf_we, pc_sel, lsu_req_valid, wb_sel}, 0);
        rst_n = 1'b1;
        step();

        run(tq[0], 0, 0, 0);
        run(tq[1], 0, 0, 0);
        run(tq[2], 0, 0, 1);
        run(tq[3], 0, 0, 1);
        run(tq[4], 3, 2, 0);
        run(tq[5], 0, 0, 0);
        run(tq[6], 0, 0, 0);
        run(tq[7], 0, 0, 0);

        // sw with the LSU never ready: timeout after exactly 8 MEM cycles
        fetch(32'h0020_a023);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("to_mem", {state_o, lsu_req_valid, lsu_we}, {3'd3, 2'b11});
            step();
        end
        chk("to_halt", {halt, illegal, state_o}, {2'b11, 3'd5});
        chk("to_strobes", {lsu_req_valid, pc_we, rf_we, inst_ready}, 0);
        do_reset();

        // async reset while a load request is pending
        fetch(32'h0000_a103);
        step();
        chk("arst_req_before", lsu_req_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_req_drop", {lsu_req_valid, state_o}, 0);
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 300; n++)
            run(tq[$urandom_range(0, tq.size() - 1)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
